// File: rtl/collide_scheduler.sv
// Time-multiplexes one circle-hit checker across NUM_OBJ object slots and gathers a hit mask.
// Optional WAIT timeout enabled by defining COLLIDE_SCHED_TIMEOUT_EN.
module collide_scheduler #(
  parameter int unsigned NUM_OBJ = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_start,
  input  logic [NUM_OBJ-1:0]    obj_en,
  input  logic [16*NUM_OBJ-1:0] obj_x,
  input  logic [16*NUM_OBJ-1:0] obj_y,
  input  logic [16*NUM_OBJ-1:0] obj_r2,
  input  logic [15:0]           ply_x,
  input  logic [15:0]           ply_y,
  output logic                  chk_start,
  output logic [15:0]           chk_x,
  output logic [15:0]           chk_y,
  output logic [15:0]           chk_dx,
  output logic [15:0]           chk_dy,
  output logic [15:0]           chk_r2,
  input  logic                  chk_valid,
  input  logic                  chk_ready,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_OBJ-1:0]    hit_mask,
  output logic                  hit_any,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_OBJ - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OBJ-1:0] en_q;
  logic [NUM_OBJ-1:0] work_q, work_d;
  logic [15:0]        px_q, py_q;
  logic               latch, load_ops, advance, finish;

`ifdef COLLIDE_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;
  logic            tmo;
  logic            tmo_err_q;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    work_d   = work_q;
    latch    = 1'b0;
    load_ops = 1'b0;
    advance  = 1'b0;
    finish   = 1'b0;
`ifdef COLLIDE_SCHED_TIMEOUT_EN
    tmo      = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (scan_start) begin
          latch   = 1'b1;
          work_d  = '0;
          idx_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (en_q[idx_q]) begin
          load_ops = 1'b1;
          state_d  = StWait;
        end else begin
          advance = 1'b1;
        end
      end
      StWait: begin
        if (chk_ready) begin
          work_d[idx_q] = chk_valid;
          advance       = 1'b1;
        end
`ifdef COLLIDE_SCHED_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          work_d[idx_q] = 1'b0;
          advance       = 1'b1;
          tmo           = 1'b1;
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Disabled slots and retired checks share the same step to the next slot.
    if (advance) begin
      if (idx_q == LastIdx) begin
        state_d = StDone;
        finish  = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = StIssue;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      en_q      <= '0;
      work_q    <= '0;
      px_q      <= '0;
      py_q      <= '0;
      hit_mask  <= '0;
      chk_start <= 1'b0;
      chk_x     <= '0;
      chk_y     <= '0;
      chk_dx    <= '0;
      chk_dy    <= '0;
      chk_r2    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      work_q    <= work_d;
      chk_start <= load_ops;
      if (latch) begin
        en_q <= obj_en;
        px_q <= ply_x;
        py_q <= ply_y;
      end
      if (load_ops) begin
        chk_x  <= obj_x[{idx_q, 4'b0000} +: 16];
        chk_y  <= obj_y[{idx_q, 4'b0000} +: 16];
        chk_r2 <= obj_r2[{idx_q, 4'b0000} +: 16];
        chk_dx <= px_q;
        chk_dy <= py_q;
      end
      if (finish) begin
        hit_mask <= work_d;
      end
    end
  end

`ifdef COLLIDE_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (load_ops) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (latch) begin
        tmo_err_q <= 1'b0;
      end else if (tmo) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = tmo_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_err    = 1'b0;
`endif

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign hit_any = |hit_mask;

endmodule

// File: doc/collide_scheduler.md
# collide_scheduler

Time-multiplexes one distance-check unit (circle-hit checker: `valid = r2 >= (x-dx)^2 + (y-dy)^2`) across NUM_OBJ game-object slots. On each scan request it walks the slots in index order, issues one check per enabled object against the latched player position, and collects the results into a hit bitmask. It sits between the per-frame game logic and the shared checker instance.

## Interface
- NUM_OBJ, 8, number of object slots (2..16)
- IDX_W, 3, slot index width, equal to clog2(NUM_OBJ)
- TIMEOUT, 15, maximum WAIT cycles per check (used only with the macro)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- scan_start  in  1  request a scan; sampled only in IDLE
- obj_en  in  NUM_OBJ  slot enable mask, latched at scan start
- obj_x, obj_y  in  16*NUM_OBJ  signed object centres; slot i at bits [16i+15:16i]
- obj_r2  in  16*NUM_OBJ  unsigned squared hit radius per slot
- ply_x, ply_y  in  16  signed player position, latched at scan start
- chk_start  out  1  one-cycle start pulse to the checker
- chk_x, chk_y, chk_dx, chk_dy, chk_r2  out  16 each  checker operands; chk_x/chk_y carry the object, chk_dx/chk_dy the player
- chk_valid  in  1  checker result; meaningful only while chk_ready=1
- chk_ready  in  1  one-cycle checker completion pulse
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the scan completes
- hit_mask  out  NUM_OBJ  result of the last completed scan
- hit_any  out  1  OR-reduction of hit_mask
- timeout_err  out  1  sticky flag for the last scan (macro-dependent)

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: when scan_start=1, latch obj_en, ply_x and ply_y. Clear the working mask and idx. Go to ISSUE.
- ISSUE (slot idx):
  - If en[idx]=1, register chk_start=1 and all operands from slot idx, then go to WAIT.
  - If en[idx]=0, skip the slot: its result bit is 0 and no chk_start is issued. Go to ISSUE at idx+1, or to DONE if idx=NUM_OBJ-1.
- WAIT: on chk_ready=1, write chk_valid into working bit idx. Then advance exactly as in the skip case.
- DONE: copy the working mask to hit_mask, assert done for one cycle, go to IDLE.
- Operands are registered. They stay stable from the chk_start cycle until the next chk_start. They are sampled from the live obj_* bus at ISSUE, so software must hold obj_* stable while busy=1.
- Ignored inputs:
  - scan_start while busy=1.
  - chk_ready/chk_valid outside WAIT, including stray pulses after reset.
- hit_mask and hit_any change only in the DONE cycle and hold until the next DONE.
- Reset values: state IDLE, idx 0, all outputs 0, working mask 0. Reset mid-scan aborts the scan with no done pulse and hit_mask=0.

## Timing
- chk_start is high for exactly one cycle: the first cycle in WAIT.
- Checker latency L is not fixed. The block waits for chk_ready. With the standard checker, chk_ready arrives 3 cycles after chk_start.
- Per-slot cost:
  - Disabled slot: 1 cycle.
  - Enabled slot: 1 cycle (ISSUE) plus the cycles spent in WAIT up to and including the chk_ready cycle.
- Scan latency: done is high in the cycle after the final slot retires. With all slots disabled and NUM_OBJ=4, done is high in the cycle after the 4th edge following the sampling edge.
- busy rises on the edge that samples scan_start and falls on the edge leaving DONE.
- A new scan_start may be sampled in the first IDLE cycle after DONE.

## Configuration
- Macro: COLLIDE_SCHED_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter counts from chk_start.
  - If it reaches TIMEOUT with no chk_ready, the slot's bit becomes 0, timeout_err is set, and the scan advances.
  - A chk_ready arriving later is ignored, or is taken as the next slot's result only if it falls inside that slot's WAIT.
  - timeout_err clears when the next scan_start is accepted.
- Undefined: WAIT has no exit except chk_ready, and timeout_err is tied to 0.

## Test plan
- Reset, then idle: all outputs 0. A stray chk_ready=1 in IDLE changes nothing.
- NUM_OBJ=4, all enabled, player at (0,0), objects (3,4), (10,0), (-3,-4), (0,0), all r2=25, checker model L=3:
  - hit_mask=4'b1101, hit_any=1.
  - 4 chk_start pulses, with operands correct at each pulse.
  - done pulses once.
- obj_en=4'b0100 with slot 2 a hit: exactly one chk_start carrying slot-2 operands. hit_mask=4'b0100.
- scan_start re-asserted while busy: no restart. hit_mask matches the first scan. A second scan_start after done runs a full new scan.
- Reset asserted during WAIT of slot 1: outputs go 0 immediately (asynchronously), no done, and a pending chk_ready is ignored.
- With COLLIDE_SCHED_TIMEOUT_EN and TIMEOUT=15, checker never replies on slot 0:
  - WAIT exits after 15 cycles.
  - timeout_err=1 and bit0=0.
  - The remaining slots are still checked.
  - timeout_err clears on the next scan_start.
